// File: rtl/xpose_bank_ctrl.sv
// Address and rotation controller for the multi-bank transpose buffer. Tiles are stored
// diagonally across NUM_PE memories so rows stream in and columns stream out at one beat per cycle.
module xpose_bank_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_PE         = 8,
  parameter int NUM_BANKS      = 2,
  parameter int READ_LAT       = 1,
  parameter int ROW_BITS       = $clog2(NUM_PE),
  parameter int BANK_BITS      = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1,
  parameter int ADDR_WIDTH     = BANK_BITS + ROW_BITS,
  parameter int SHIFT_AMT_BITS = $clog2(DATA_WIDTH * NUM_PE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic                              in_mode,
  output logic                              wen,
  output logic [NUM_PE-1:0][ADDR_WIDTH-1:0] write_addr,
  output logic [SHIFT_AMT_BITS-1:0]         in_shift_amt,
  input  logic                              rd_rdy,
  output logic                              ren,
  output logic [NUM_PE-1:0][ADDR_WIDTH-1:0] read_addr,
  output logic                              out_val,
  output logic                              out_last,
  output logic [SHIFT_AMT_BITS-1:0]         out_shift_amt,
  output logic [BANK_BITS:0]                tiles_full
);
  localparam int                   CNT_W     = BANK_BITS + 1;
  localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(NUM_PE - 1);
  localparam logic [BANK_BITS-1:0] LAST_BANK = BANK_BITS'(NUM_BANKS - 1);

  logic [BANK_BITS-1:0] r_wr_bank;
  logic [ROW_BITS-1:0]  r_wr_row;
  logic [BANK_BITS-1:0] r_rd_bank;
  logic [ROW_BITS-1:0]  r_rd_row;
  logic [NUM_BANKS-1:0] r_full;
  logic [NUM_BANKS-1:0] r_mode;
  logic [CNT_W-1:0]     r_tiles_full;

  logic [READ_LAT-1:0]                     r_vld_p;
  logic [READ_LAT-1:0]                     r_last_p;
  logic [READ_LAT-1:0][SHIFT_AMT_BITS-1:0] r_shift_p;

  logic                      w_wr_last;
  logic                      w_rd_last;
  logic                      w_wr_mode;
  logic                      w_rd_mode;
  logic [NUM_BANKS-1:0]      w_full_nxt;
  logic [SHIFT_AMT_BITS-1:0] w_rd_shift;

  function automatic logic [SHIFT_AMT_BITS-1:0] f_lane_shift(input logic [ROW_BITS-1:0] row);
    return SHIFT_AMT_BITS'(row) * SHIFT_AMT_BITS'(DATA_WIDTH);
  endfunction

  function automatic logic [BANK_BITS-1:0] f_next_bank(input logic [BANK_BITS-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BANK_BITS'(1);
  endfunction

  function automatic logic [CNT_W-1:0] f_popcnt(input logic [NUM_BANKS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BANKS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  assign w_wr_last = (r_wr_row == LAST_ROW);
  assign w_rd_last = (r_rd_row == LAST_ROW);
  assign w_wr_mode = r_mode[r_wr_bank];
  assign w_rd_mode = r_mode[r_rd_bank];

  // A bank being filled is never full, so a same-cycle read always targets another bank.
  assign in_rdy       = ~r_full[r_wr_bank];
  assign wen          = in_val & in_rdy;
  assign ren          = rd_rdy & r_full[r_rd_bank];
  assign in_shift_amt = w_wr_mode ? f_lane_shift(r_wr_row) : '0;
  assign w_rd_shift   = w_rd_mode ? f_lane_shift(r_rd_row) : '0;

  // Diagonal storage: row r lane c lives in PE (c+r), so column k sits at row (p-k) in PE p.
  always_comb begin
    for (int p = 0; p < NUM_PE; p++) begin
      write_addr[p] = {r_wr_bank, r_wr_row};
      read_addr[p]  = w_rd_mode ? {r_rd_bank, ROW_BITS'(p) - r_rd_row} : {r_rd_bank, r_rd_row};
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (wen && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (ren && w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank    <= '0;
      r_wr_row     <= '0;
      r_rd_bank    <= '0;
      r_rd_row     <= '0;
      r_full       <= '0;
      r_mode       <= '0;
      r_tiles_full <= '0;
    end else begin
      if (wen) begin
        if (r_wr_row == '0) r_mode[r_wr_bank] <= in_mode;
        if (w_wr_last) begin
          r_wr_row  <= '0;
          r_wr_bank <= f_next_bank(r_wr_bank);
        end else begin
          r_wr_row  <= r_wr_row + ROW_BITS'(1);
        end
      end
      if (ren) begin
        if (w_rd_last) begin
          r_rd_row  <= '0;
          r_rd_bank <= f_next_bank(r_rd_bank);
        end else begin
          r_rd_row  <= r_rd_row + ROW_BITS'(1);
        end
      end
      r_full       <= w_full_nxt;
      r_tiles_full <= f_popcnt(w_full_nxt);
    end
  end

  // Stage p0 captures the read issue; later stages track the memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p   <= '0;
      r_last_p  <= '0;
      r_shift_p <= '0;
    end else begin
      r_vld_p[0]   <= ren;
      r_last_p[0]  <= ren & w_rd_last;
      r_shift_p[0] <= w_rd_shift;
      for (int i = 1; i < READ_LAT; i++) begin
        r_vld_p[i]   <= r_vld_p[i-1];
        r_last_p[i]  <= r_last_p[i-1];
        r_shift_p[i] <= r_shift_p[i-1];
      end
    end
  end

  assign out_val       = r_vld_p[READ_LAT-1];
  assign out_last      = r_last_p[READ_LAT-1];
  assign out_shift_amt = r_shift_p[READ_LAT-1];
  assign tiles_full    = r_tiles_full;

endmodule

// File: tb/tb_xpose_bank_ctrl.sv
// Bench for xpose_bank_ctrl: cycle model of the controller plus a PE-memory data path,
// with a scoreboard of expected output rows built from the input tiles.
module tb_xpose_bank_ctrl;
  localparam int DW = 64;
  localparam int NP = 8;
  localparam int NB = 2;
  localparam int RL = 1;
  localparam int AW = 4;
  localparam int SB = 9;
  localparam int RW = DW * NP;

  typedef logic [511:0] cv_t;
  typedef struct { logic [RW-1:0] data; logic last; } sb_t;
  typedef struct {
    logic v; logic rr; logic e_wen; int e_ish; logic e_ren; int e_k;
    logic e_ov; logic e_ol; int e_osh;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_val = 1'b0, in_mode = 1'b0, rd_rdy = 1'b0;
  logic in_rdy, wen, ren, out_val, out_last;
  logic [NP-1:0][AW-1:0] write_addr, read_addr;
  logic [SB-1:0] in_shift_amt, out_shift_amt;
  logic [1:0] tiles_full;
  logic [RW-1:0] in_data = '0;

  int checks = 0, errors = 0;
  int drv_tile = 0, drv_row = 0, acc = 0;
  int run_cur = 0, run_max = 0, lastcnt = 0;

  // Reference model state
  bit mdl_on = 1'b0;
  int mb_wr_bank, mb_wr_row, mb_rd_bank, mb_rd_row;
  bit mb_full [NB];
  bit mb_mode [NB];
  logic [RW-1:0] tb_tile [NB][NP];
  logic [DW-1:0] mem [NP][NB*NP];
  logic dl_val [RL];
  logic dl_last [RL];
  logic [SB-1:0] dl_shift [RL];
  logic [RW-1:0] dl_data [RL];
  sb_t sb_q [$];

  xpose_bank_ctrl #(.DATA_WIDTH(DW), .NUM_PE(NP), .NUM_BANKS(NB), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_mode(in_mode), .wen(wen),
    .write_addr(write_addr), .in_shift_amt(in_shift_amt), .rd_rdy(rd_rdy), .ren(ren),
    .read_addr(read_addr), .out_val(out_val), .out_last(out_last),
    .out_shift_amt(out_shift_amt), .tiles_full(tiles_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rot_l(input logic [RW-1:0] d, input int amt);
    logic [2*RW-1:0] t;
    t = {d, d} << amt;
    return t[2*RW-1:RW];
  endfunction

  function automatic logic [RW-1:0] rot_r(input logic [RW-1:0] d, input int amt);
    logic [2*RW-1:0] t;
    t = {d, d} >> amt;
    return t[RW-1:0];
  endfunction

  function automatic logic [RW-1:0] mk_row(input int t, input int r);
    logic [RW-1:0] x;
    for (int c = 0; c < NP; c++) x[c*DW +: DW] = DW'(t*64 + r*NP + c);
    return x;
  endfunction

  logic e_rdy, e_wen, e_ren;
  int pc;
  logic [NP*AW-1:0] ewa, era;
  logic [SB-1:0] e_rsh;
  logic [RW-1:0] rdv, wdv, got, exr;
  sb_t ent;

  always @(negedge clk) begin
    if (mdl_on) begin
      e_rdy = !mb_full[mb_wr_bank];
      e_wen = in_val && e_rdy;
      e_ren = rd_rdy && mb_full[mb_rd_bank];
      chk("in_rdy", cv_t'(in_rdy), cv_t'(e_rdy));
      chk("wen", cv_t'(wen), cv_t'(e_wen));
      chk("ren", cv_t'(ren), cv_t'(e_ren));
      pc = 0;
      for (int b = 0; b < NB; b++) pc += int'(mb_full[b]);
      chk("tiles_full", cv_t'(tiles_full), cv_t'(pc));
      chk("out_val", cv_t'(out_val), cv_t'(dl_val[RL-1]));
      if (dl_val[RL-1]) begin
        chk("out_last", cv_t'(out_last), cv_t'(dl_last[RL-1]));
        chk("out_shift", cv_t'(out_shift_amt), cv_t'(dl_shift[RL-1]));
        got = rot_r(dl_data[RL-1], int'(out_shift_amt));
        if (sb_q.size() > 0) begin
          ent = sb_q.pop_front();
          chk("out_row", cv_t'(got), cv_t'(ent.data));
          chk("sb_last", cv_t'(out_last), cv_t'(ent.last));
        end else begin
          checks++; errors++;
          $display("FAIL sb_underflow got out_val=1 want no output at %0t", $time);
        end
      end
      if (out_val === 1'b1) begin
        run_cur++;
        if (run_cur > run_max) run_max = run_cur;
        if (out_last === 1'b1) lastcnt++;
      end else run_cur = 0;
      if (e_wen) begin
        for (int p = 0; p < NP; p++) ewa[p*AW +: AW] = AW'(mb_wr_bank*NP + mb_wr_row);
        chk("write_addr", cv_t'(write_addr), cv_t'(ewa));
        chk("in_shift", cv_t'(in_shift_amt),
            cv_t'((mb_wr_row != 0 && mb_mode[mb_wr_bank]) ? mb_wr_row*DW : 0));
      end
      e_rsh = mb_mode[mb_rd_bank] ? SB'(mb_rd_row*DW) : '0;
      if (e_ren) begin
        for (int p = 0; p < NP; p++)
          era[p*AW +: AW] = mb_mode[mb_rd_bank] ? AW'(mb_rd_bank*NP + ((p - mb_rd_row) & (NP-1)))
                                                : AW'(mb_rd_bank*NP + mb_rd_row);
        chk("read_addr", cv_t'(read_addr), cv_t'(era));
      end
      if (!rst) begin
        rdv = '0;
        if (ren === 1'b1) for (int p = 0; p < NP; p++) rdv[p*DW +: DW] = mem[p][read_addr[p]];
        if (wen === 1'b1) begin
          wdv = rot_l(in_data, int'(in_shift_amt));
          for (int p = 0; p < NP; p++) mem[p][write_addr[p]] = wdv[p*DW +: DW];
        end
        for (int i = RL-1; i > 0; i--) begin
          dl_val[i] = dl_val[i-1]; dl_last[i] = dl_last[i-1];
          dl_shift[i] = dl_shift[i-1]; dl_data[i] = dl_data[i-1];
        end
        dl_val[0] = e_ren; dl_last[0] = e_ren && (mb_rd_row == NP-1);
        dl_shift[0] = e_rsh; dl_data[0] = rdv;
        if (e_wen) begin
          tb_tile[mb_wr_bank][mb_wr_row] = in_data;
          if (mb_wr_row == 0) mb_mode[mb_wr_bank] = in_mode;
          if (mb_wr_row == NP-1) begin
            for (int k = 0; k < NP; k++) begin
              for (int r = 0; r < NP; r++)
                exr[r*DW +: DW] = mb_mode[mb_wr_bank] ? tb_tile[mb_wr_bank][r][k*DW +: DW]
                                                      : tb_tile[mb_wr_bank][k][r*DW +: DW];
              ent.data = exr; ent.last = (k == NP-1);
              sb_q.push_back(ent);
            end
            mb_full[mb_wr_bank] = 1'b1;
            mb_wr_row = 0; mb_wr_bank = (mb_wr_bank + 1) % NB;
          end else mb_wr_row++;
        end
        if (e_ren) begin
          if (mb_rd_row == NP-1) begin
            mb_full[mb_rd_bank] = 1'b0;
            mb_rd_row = 0; mb_rd_bank = (mb_rd_bank + 1) % NB;
          end else mb_rd_row++;
        end
      end
    end
    if (rst) begin
      mb_wr_bank = 0; mb_wr_row = 0; mb_rd_bank = 0; mb_rd_row = 0;
      for (int b = 0; b < NB; b++) begin mb_full[b] = 1'b0; mb_mode[b] = 1'b0; end
      for (int i = 0; i < RL; i++) begin
        dl_val[i] = 1'b0; dl_last[i] = 1'b0; dl_shift[i] = '0; dl_data[i] = '0;
      end
      sb_q.delete();
      mdl_on = 1'b1;
    end
  end

  task automatic cyc(input logic v, input logic m, input logic rr, input logic rs);
    @(posedge clk); #1;
    rst = rs; in_val = v; in_mode = m; rd_rdy = rr; in_data = mk_row(drv_tile, drv_row);
    @(negedge clk);
    if (!rs && v && in_rdy === 1'b1) begin
      acc++;
      if (drv_row == NP-1) begin drv_row = 0; drv_tile++; end
      else drv_row++;
    end
  endtask

  vec_t tbl [18];
  logic [NP*AW-1:0] xa;
  int stall, first_rdy;

  initial begin
    for (int i = 0; i < 18; i++) begin
      tbl[i].v = (i < 8); tbl[i].rr = 1'b1; tbl[i].e_wen = (i < 8); tbl[i].e_ish = 64*i;
      tbl[i].e_ren = (i >= 8 && i < 16); tbl[i].e_k = i - 8;
      tbl[i].e_ov = (i >= 9 && i <= 16); tbl[i].e_ol = (i == 16); tbl[i].e_osh = 64*(i-9);
    end

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("rst_in_rdy", cv_t'(in_rdy), cv_t'(1));
    chk("rst_wen", cv_t'(wen), cv_t'(0));
    chk("rst_ren", cv_t'(ren), cv_t'(0));
    chk("rst_out_val", cv_t'(out_val), cv_t'(0));
    chk("rst_out_last", cv_t'(out_last), cv_t'(0));
    chk("rst_tiles_full", cv_t'(tiles_full), cv_t'(0));
    chk("rst_in_shift", cv_t'(in_shift_amt), cv_t'(0));
    chk("rst_out_shift", cv_t'(out_shift_amt), cv_t'(0));

    // Single transpose tile, table driven
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].v, 1'b1, tbl[i].rr, 1'b0);
      chk("t_wen", cv_t'(wen), cv_t'(tbl[i].e_wen));
      if (tbl[i].e_wen) begin
        chk("t_in_shift", cv_t'(in_shift_amt), cv_t'(tbl[i].e_ish));
        for (int p = 0; p < NP; p++) xa[p*AW +: AW] = AW'(i);
        chk("t_write_addr", cv_t'(write_addr), cv_t'(xa));
      end
      chk("t_ren", cv_t'(ren), cv_t'(tbl[i].e_ren));
      if (tbl[i].e_ren) begin
        for (int p = 0; p < NP; p++) xa[p*AW +: AW] = AW'((p - tbl[i].e_k) & 7);
        chk("t_read_addr", cv_t'(read_addr), cv_t'(xa));
      end
      chk("t_out_val", cv_t'(out_val), cv_t'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk("t_out_last", cv_t'(out_last), cv_t'(tbl[i].e_ol));
        chk("t_out_shift", cv_t'(out_shift_amt), cv_t'(tbl[i].e_osh));
      end
    end

    // Continuous stream of 4 tiles
    run_max = 0; stall = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1, 1, 1, 0);
      if (in_rdy !== 1'b1) stall++;
    end
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0);
    chk("stream_stalls", cv_t'(stall), cv_t'(0));
    chk("stream_out_run", cv_t'(run_max), cv_t'(32));

    // Backpressure: three tiles offered with reads blocked
    acc = 0;
    for (int i = 0; i < 24; i++) cyc(1, 1, 0, 0);
    chk("bp_accepted", cv_t'(acc), cv_t'(16));
    chk("bp_tiles_full", cv_t'(tiles_full), cv_t'(2));
    chk("bp_in_rdy", cv_t'(in_rdy), cv_t'(0));
    first_rdy = -1;
    for (int i = 0; i < 40 && acc < 24; i++) begin
      cyc(1, 1, 1, 0);
      if (in_rdy === 1'b1 && first_rdy < 0) first_rdy = i;
    end
    chk("bp_reassert_cycle", cv_t'(first_rdy), cv_t'(8));
    chk("bp_total_accepted", cv_t'(acc), cv_t'(24));
    for (int i = 0; i < 30; i++) cyc(0, 1, 1, 0);

    // Alternating read readiness
    acc = 0; lastcnt = 0;
    for (int i = 0; i < 80; i++) cyc(acc < 16, 1'b1, logic'(i & 1), 1'b0);
    chk("alt_accepted", cv_t'(acc), cv_t'(16));
    chk("alt_last_count", cv_t'(lastcnt), cv_t'(2));

    // Bypass tile then transpose tile
    acc = 0; lastcnt = 0;
    for (int i = 0; i < 40; i++) cyc(acc < 16, acc >= 8, 1'b1, 1'b0);
    chk("mode_last_count", cv_t'(lastcnt), cv_t'(2));

    // Reset with one full tile and a partial tile held
    acc = 0;
    for (int i = 0; i < 13; i++) cyc(1, 1, 0, 0);
    chk("mid_accepted", cv_t'(acc), cv_t'(13));
    chk("mid_tiles_full", cv_t'(tiles_full), cv_t'(1));
    cyc(0, 0, 0, 1);
    drv_row = 0; drv_tile++;
    cyc(0, 0, 0, 0);
    chk("post_rst_tiles_full", cv_t'(tiles_full), cv_t'(0));
    chk("post_rst_in_rdy", cv_t'(in_rdy), cv_t'(1));
    chk("post_rst_out_val", cv_t'(out_val), cv_t'(0));
    cyc(1, 1, 1, 0);
    chk("post_rst_wen", cv_t'(wen), cv_t'(1));
    chk("post_rst_addr", cv_t'(write_addr), cv_t'(0));
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 1, 0);
    chk("sb_drained", cv_t'(sb_q.size()), cv_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xpose_bank_ctrl.md
Name: xpose_bank_ctrl

Overview:
Address and rotation controller for the multi-bank matrix-transpose buffer. It writes NUM_PE-row tiles into NUM_PE single-port-per-side PE memories and reads them back as columns, using diagonal (skewed) storage and barrel-rotate amounts. It supports NUM_BANKS tile buffers in a ring, valid/ready backpressure on both sides, a READ_LAT-aligned output pipeline, and a per-tile transpose/bypass mode. It sits between the input rotator, the PE memory array and the output rotator.

Parameters:
DATA_WIDTH, 64, element width in bits.
NUM_PE, 8, lanes per row and rows per tile; power of 2, at least 2.
NUM_BANKS, 2, tile buffers in the ring; 2 to 8.
READ_LAT, 1, PE memory read latency in cycles; at least 1.
ROW_BITS, $clog2(NUM_PE), row index width.
BANK_BITS, max(1,$clog2(NUM_BANKS)), bank index width.
ADDR_WIDTH, BANK_BITS+ROW_BITS, PE memory address width.
SHIFT_AMT_BITS, $clog2(DATA_WIDTH*NUM_PE), rotate amount width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_val  in  1  input row valid
in_rdy  out  1  controller can accept a row
in_mode  in  1  1 = transpose, 0 = bypass; sampled on the first row of each tile
wen  out  1  PE memory write enable
write_addr  out  NUM_PE x ADDR_WIDTH  per-PE write address
in_shift_amt  out  SHIFT_AMT_BITS  input rotate-left amount in bits
rd_rdy  in  1  downstream guarantees acceptance of data READ_LAT cycles later
ren  out  1  PE memory read enable
read_addr  out  NUM_PE x ADDR_WIDTH  per-PE read address
out_val  out  1  output row valid, aligned with memory data
out_last  out  1  last row of a tile, qualified by out_val
out_shift_amt  out  SHIFT_AMT_BITS  output rotate-right amount, aligned with out_val
tiles_full  out  BANK_BITS+1  number of banks holding a complete, unread tile

Behaviour:
- State: wr_bank, wr_row, rd_bank, rd_row counters; full[NUM_BANKS] flags; mode[NUM_BANKS] flags; READ_LAT-deep pipeline of {val, last, shift}.
- Reset: all counters, flags and the pipeline are cleared. in_rdy=1, wen=0, ren=0, out_val=0, out_last=0, tiles_full=0, both shift amounts=0. A reset mid-tile discards all partial and complete tiles.
- in_rdy = ~full[wr_bank]. wen = in_val & in_rdy. write_addr and in_shift_amt are combinational from the counters.
- Write beat at row r: every PE gets write_addr = {wr_bank, r}. In transpose mode in_shift_amt = r*DATA_WIDTH, so input lane c is stored in PE (c+r) mod NUM_PE. In bypass mode in_shift_amt = 0.
- On a beat with r=0, the controller latches mode[wr_bank] from in_mode. On the beat with r=NUM_PE-1 it sets full[wr_bank], clears wr_row and advances wr_bank mod NUM_BANKS. Otherwise wr_row increments.
- ren = rd_rdy & full[rd_bank].
- Read beat k, transpose mode: PE p gets read_addr = {rd_bank, (p-k) mod NUM_PE}, and shift = k*DATA_WIDTH. Output row k is column k of the input tile.
- Read beat k, bypass mode: all PEs get read_addr = {rd_bank, k}, and shift = 0.
- On the read beat with k=NUM_PE-1 the controller clears full[rd_bank], clears rd_row and advances rd_bank. Otherwise rd_row increments.
- out_val, out_last and out_shift_amt equal ren, (ren & k==NUM_PE-1) and the shift, each delayed exactly READ_LAT cycles.
- Latency: if the last row is written at cycle t and rd_rdy=1, the first ren occurs at t+1 and the first out_val at t+1+READ_LAT.
- A write and a read in the same cycle always target different banks, because a bank is never both full and being written.
- When the last read of bank b and the last write into bank b-1 happen in the same cycle, both flag updates take effect.
- Bank b becomes writable in the cycle after its last read issue. The write to row 0 is safe because all reads from b have already issued.
- tiles_full is the registered popcount of full[]. With all banks full, in_rdy=0 and no wen is issued regardless of in_val.
- Row counters wrap at NUM_PE by exact compare, not by overflow. Address subtraction is modulo NUM_PE over ROW_BITS.
- Back-to-back tiles stream at 1 row per cycle per side, with no idle cycle between tiles.

Test Plan:
- Single tile (NUM_PE=8, READ_LAT=1): rows r with lane c = 8r+c, in transpose mode, rd_rdy=1. Required: in_shift_amt 0,64,...,448. Read beat k gives PE p addr (p-k) mod 8. out_val starts 2 cycles after the last write. After the data-path model, output row k lane r = 8r+k. out_last on row 7.
- Continuous stream of 4 tiles with in_val=1 and rd_rdy=1: required in_rdy stays 1, banks used in order 0,1,0,1, and out_val is continuous for 32 cycles after the initial fill latency.
- rd_rdy=0 while writing 3 tiles (NUM_BANKS=2): tiles_full reaches 2 and in_rdy drops after 16 rows. Raising rd_rdy reasserts in_rdy the cycle after the 8th read issue.
- Alternating rd_rdy 1/0: reads pause and resume at the same k. out_shift_amt stays aligned with out_val, and out_last asserts exactly once per tile.
- Bypass tile followed by transpose tile: the first tile reads all addrs = k with shift 0 and returns rows unchanged. The second tile is transposed, showing per-bank mode retention.
- rst asserted after 5 rows of a tile and while one tile is full: next cycle tiles_full=0, in_rdy=1 and out_val=0. A new tile then writes from bank 0, row 0.
